// File: rtl/legv8_sequencer.sv
// Multi-cycle LEGv8 control unit: sequences fetch/execute and drives the
// datapath control word and constant from the instruction register.
module legv8_sequencer #(
  parameter logic [4:0] FS_ADD   = 5'b01000,
  parameter logic [4:0] FS_SUB   = 5'b01001,
  parameter logic [4:0] FS_AND   = 5'b00000,
  parameter logic [4:0] FS_ORR   = 5'b00100,
  parameter logic [4:0] FS_PASSA = 5'b11000,
  parameter logic [1:0] MEM_SIZE = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  cur_status,
  output logic [39:0] ControlWord,
  output logic [63:0] constant,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam int unsigned CW_W = 40;

  typedef enum logic [2:0] {
    S_INIT  = 3'b000,
    S_FETCH = 3'b001,
    S_EXEC  = 3'b010,
    S_EXEC2 = 3'b011,
    S_HALT  = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_CBZ, OP_B
  } op_t;

  state_t      cur_state, next_state;
  op_t         op;
  logic        zf;
  logic        unused_status;

  logic [2:0]  ns_f;
  logic        as_f, bsel_f, il_f, c0_f, mw_f, rw_f;
  logic [1:0]  ds_f, ps_f, size_f;
  logic [4:0]  fs_f, da_f, sa_f, sb_f;
  logic [63:0] const_f;

  assign unused_status = ^cur_status[3:1];

  // Opcode decode: 11-bit opcodes first, then ADDI/SUBI, CBZ, B
  always_comb begin
    op = OP_NONE;
    case (IR[31:21])
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10001010000: op = OP_AND;
      11'b10101010000: op = OP_ORR;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      default: begin
        if (IR[31:22] == 10'b1001000100)      op = OP_ADDI;
        else if (IR[31:22] == 10'b1101000100) op = OP_SUBI;
        else if (IR[31:24] == 8'b10110100)    op = OP_CBZ;
        else if (IR[31:26] == 6'b000101)      op = OP_B;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_state <= S_INIT;
    else       cur_state <= next_state;
  end

  // Next state and control fields
  always_comb begin
    next_state = cur_state;
    as_f = 1'b0; bsel_f = 1'b0; il_f = 1'b0; c0_f = 1'b0;
    mw_f = 1'b0; rw_f = 1'b0;
    ds_f = 2'b00; ps_f = 2'b00; size_f = 2'b00;
    fs_f = 5'd0; da_f = 5'd0; sa_f = 5'd0; sb_f = 5'd0;
    const_f = 64'd0;
    case (cur_state)
      S_INIT: next_state = S_FETCH;
      S_FETCH: begin
        next_state = S_EXEC;
        as_f = 1'b1; ds_f = 2'b11; il_f = 1'b1; ps_f = 2'b01; size_f = 2'b10;
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
            da_f = IR[4:0]; sa_f = IR[9:5]; sb_f = IR[20:16]; rw_f = 1'b1;
            if (op == OP_ADDI || op == OP_SUBI) begin
              bsel_f  = 1'b1;
              const_f = {52'd0, IR[21:10]};
            end
            case (op)
              OP_SUB, OP_SUBI: begin fs_f = FS_SUB; c0_f = 1'b1; end
              OP_AND:          fs_f = FS_AND;
              OP_ORR:          fs_f = FS_ORR;
              default:         fs_f = FS_ADD;
            endcase
          end
          OP_LDUR, OP_STUR: begin
            sa_f = IR[9:5]; da_f = IR[4:0]; bsel_f = 1'b1; fs_f = FS_ADD;
            size_f  = MEM_SIZE;
            const_f = {{55{IR[20]}}, IR[20:12]};
            if (op == OP_STUR) begin
              sb_f = IR[4:0]; ds_f = 2'b01; mw_f = 1'b1;
            end else begin
              ds_f = 2'b11; rw_f = 1'b1;
            end
          end
          OP_B: begin
            // PC already advanced by 4 during fetch
            ps_f    = 2'b10;
            const_f = {{36{IR[25]}}, IR[25:0], 2'b00} - 64'd4;
          end
          OP_CBZ: begin
            next_state = S_EXEC2;
            sa_f = IR[4:0]; fs_f = FS_PASSA;
          end
          default: next_state = S_HALT;
        endcase
      end
      S_EXEC2: begin
        next_state = S_FETCH;
        if (zf) begin
          ps_f    = 2'b10;
          const_f = {{43{IR[23]}}, IR[23:5], 2'b00} - 64'd4;
        end
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_INIT;
    endcase
    ns_f = (cur_state == S_INIT) ? 3'b000 : 3'(next_state);
  end

  assign ControlWord = CW_W'({3'b000, ns_f, as_f, ds_f, ps_f, 1'b0, bsel_f, il_f,
                              1'b0, fs_f, c0_f, size_f, mw_f, rw_f, da_f, sa_f, sb_f});
  assign constant    = const_f;
  assign state       = 3'(cur_state);
  assign halted      = (cur_state == S_HALT);

  // Capture the ALU zero flag while CBZ passes its register through
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                zf <= 1'b0;
    else if (cur_state == S_EXEC && op == OP_CBZ) zf <= cur_status[0];
  end

  // Retired instruction counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) instr_count <= 32'd0;
    else if ((cur_state == S_EXEC && next_state == S_FETCH) || cur_state == S_EXEC2)
      instr_count <= instr_count + 32'd1;
  end

endmodule

// File: tb/tb_legv8_sequencer.sv
// Randomized bench for legv8_sequencer against an instruction-level model.
module tb_legv8_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR = 32'd0;
  logic [3:0]  cur_status = 4'd0;
  logic [39:0] ControlWord;
  logic [63:0] constant;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  legv8_sequencer dut (
    .clock(clock), .reset(reset), .IR(IR), .cur_status(cur_status),
    .ControlWord(ControlWord), .constant(constant), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  localparam int K_BAD = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_ORR = 4,
                 K_ADDI = 5, K_SUBI = 6, K_LDUR = 7, K_STUR = 8, K_CBZ = 9, K_B = 10;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: architectural phase, latched zero flag, retired count
  int          mst = 0;
  logic        mzf = 1'b0;
  logic [31:0] mcount = 32'd0;
  int          halt_cycles = 0;

  logic [31:0] ir_q[$];
  logic [3:0]  st_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] ir);
    case (ir[31:21])
      11'b10001011000: return K_ADD;
      11'b11001011000: return K_SUB;
      11'b10001010000: return K_AND;
      11'b10101010000: return K_ORR;
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      default: ;
    endcase
    if (ir[31:22] == 10'b1001000100) return K_ADDI;
    if (ir[31:22] == 10'b1101000100) return K_SUBI;
    if (ir[31:24] == 8'hB4)          return K_CBZ;
    if (ir[31:26] == 6'b000101)      return K_B;
    return K_BAD;
  endfunction

  function automatic int next_phase(input int st, input logic [31:0] ir);
    case (st)
      0: return 1;
      1: return 2;
      2: begin
        if (kind_of(ir) == K_CBZ) return 3;
        if (kind_of(ir) == K_BAD) return 7;
        return 1;
      end
      3: return 1;
      default: return 7;
    endcase
  endfunction

  // Expected control word and constant for the model's current phase
  task automatic expect_outputs(output logic [39:0] cw, output logic [63:0] k);
    logic [2:0] ns; logic as_, bsel, il, c0, mw, rw;
    logic [1:0] ds, ps, sz; logic [4:0] fs, da, sa, sb;
    longint     off;
    int         kd;
    ns = 3'(next_phase(mst, IR));
    as_ = 0; bsel = 0; il = 0; c0 = 0; mw = 0; rw = 0;
    ds = 0; ps = 0; sz = 0; fs = 0; da = 0; sa = 0; sb = 0; k = 64'd0;
    kd = kind_of(IR);
    if (mst == 0) ns = 3'd0;
    if (mst == 1) begin as_ = 1; ds = 2'd3; il = 1; ps = 2'd1; sz = 2'd2; end
    if (mst == 2) begin
      if (kd >= K_ADD && kd <= K_SUBI) begin
        da = IR[4:0]; sa = IR[9:5]; sb = IR[20:16]; rw = 1;
        fs = (kd == K_SUB || kd == K_SUBI) ? 5'b01001 :
             (kd == K_AND) ? 5'b00000 : (kd == K_ORR) ? 5'b00100 : 5'b01000;
        c0 = (kd == K_SUB || kd == K_SUBI);
        if (kd == K_ADDI || kd == K_SUBI) begin bsel = 1; k = 64'(IR[21:10]); end
      end
      if (kd == K_LDUR || kd == K_STUR) begin
        sa = IR[9:5]; da = IR[4:0]; bsel = 1; fs = 5'b01000; sz = 2'b11;
        off = longint'($signed(IR[20:12]));
        k = 64'(off);
        if (kd == K_STUR) begin sb = IR[4:0]; ds = 2'd1; mw = 1; end
        else begin ds = 2'd3; rw = 1; end
      end
      if (kd == K_B) begin
        ps = 2'd2;
        off = longint'($signed(IR[25:0])) * 4 - 4;
        k = 64'(off);
      end
      if (kd == K_CBZ) begin sa = IR[4:0]; fs = 5'b11000; end
    end
    if (mst == 3 && mzf) begin
      ps = 2'd2;
      off = longint'($signed(IR[23:5])) * 4 - 4;
      k = 64'(off);
    end
    cw = {3'b000, ns, as_, ds, ps, 1'b0, bsel, il, 1'b0, fs, c0, sz, mw, rw, da, sa, sb};
  endtask

  task automatic check_outputs();
    logic [39:0] ecw; logic [63:0] ek;
    expect_outputs(ecw, ek);
    check_eq("state",       64'(state),       64'(mst));
    check_eq("control",     64'(ControlWord), 64'(ecw));
    check_eq("constant",    constant,         ek);
    check_eq("halted",      64'(halted),      64'(mst == 7));
    check_eq("instr_count", 64'(instr_count), 64'(mcount));
  endtask

  function automatic logic [31:0] rand_ir();
    logic [10:0] rops[4];
    int r;
    rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    r = $urandom_range(0, 39);
    if (r == 0)  return 32'hFFFF_FFFF;
    if (r == 1)  return $urandom;
    if (r < 12)  return {rops[$urandom_range(0, 3)], 5'($urandom), 6'($urandom),
                         5'($urandom), 5'($urandom)};
    if (r < 18)  return {($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100,
                         12'($urandom), 5'($urandom), 5'($urandom)};
    if (r < 26)  return {($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000,
                         9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
    if (r < 34)  return {8'hB4, 19'($urandom), 5'($urandom)};
    return {6'b000101, 26'($urandom)};
  endfunction

  // One clock: check, advance model at the edge, load IR after fetch
  task automatic do_cycle();
    int prev;
    check_outputs();
    @(posedge clock);
    prev = mst;
    if (mst == 2 && kind_of(IR) == K_CBZ) mzf = cur_status[0];
    if ((mst == 2 && next_phase(mst, IR) == 1) || mst == 3) mcount = mcount + 32'd1;
    mst = next_phase(mst, IR);
    halt_cycles = (mst == 7) ? halt_cycles + 1 : 0;
    #1;
    if (prev == 1) begin
      if (ir_q.size() > 0) begin
        IR = ir_q.pop_front();
        cur_status = st_q.pop_front();
      end else begin
        IR = rand_ir();
        cur_status = 4'($urandom);
      end
    end
    @(negedge clock);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once
  task automatic do_reset();
    reset = 1'b1;
    #1;
    mst = 0; mzf = 1'b0; mcount = 32'd0; halt_cycles = 0;
    check_eq("rst_state",   64'(state),       64'd0);
    check_eq("rst_control", 64'(ControlWord), 64'd0);
    check_eq("rst_const",   constant,         64'd0);
    check_eq("rst_halted",  64'(halted),      64'd0);
    check_eq("rst_count",   64'(instr_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clock);
    do_reset();

    ir_q.push_back(32'h8B02_0020);                        st_q.push_back(4'h0);
    ir_q.push_back({11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd3}); st_q.push_back(4'h0);
    ir_q.push_back({11'b11111000000, 9'h1F8, 2'b00, 5'd4, 5'd3}); st_q.push_back(4'h0);
    ir_q.push_back({8'hB4, 19'd3, 5'd5});                 st_q.push_back(4'h1);
    ir_q.push_back({8'hB4, 19'd3, 5'd5});                 st_q.push_back(4'hE);
    ir_q.push_back({6'b000101, 26'h3FF_FFFF});            st_q.push_back(4'h0);
    ir_q.push_back(32'hFFFF_FFFF);                        st_q.push_back(4'h0);

    for (int c = 0; c < 2500; c++) begin
      do_cycle();
      if (halt_cycles > 10) do_reset();
    end

    // Reset landing in the CBZ branch phase
    do_reset();
    ir_q.push_back({8'hB4, 19'd7, 5'd9}); st_q.push_back(4'h1);
    guard = 0;
    while (mst != 3 && guard < 20) begin
      do_cycle();
      guard++;
    end
    check_eq("reach_exec2", 64'(mst), 64'd3);
    #2;
    do_reset();
    do_cycle();
    do_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/legv8_sequencer.md
Name: legv8_sequencer

Overview:
- Multi-cycle control unit that drives the 40-bit LEGv8 datapath control word and the 64-bit constant input.
- Sequences fetch/execute for a fixed LEGv8 instruction subset, using the instruction register value and the live ALU status.
- Sits beside the datapath wrapper in the CPU top level.
- Counts retired instructions and halts on an unsupported opcode.

Parameters:
- FS_ADD, 5'b01000, ALU function code for A+B (must match datapath ALU encoding)
- FS_SUB, 5'b01001, ALU code for A-B (add with C0=1 handled by sequencer)
- FS_AND, 5'b00000, ALU code for A AND B
- FS_ORR, 5'b00100, ALU code for A OR B
- FS_PASSA, 5'b11000, ALU code passing A unchanged (status Z valid)
- MEM_SIZE, 2'b11, size field for 64-bit load/store

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- IR  in  32  instruction register output of datapath
- cur_status  in  4  live ALU flags {V,C,N,Z}
- ControlWord  out  40  {CGS[2:0],NS[2:0],AS,DS[1:0],PS[1:0],PCsel,Bsel,IL,SL,FS[4:0],C0,size[1:0],MW,RW,DA[4:0],SA[4:0],SB[4:0]}
- constant  out  64  immediate/offset to datapath
- state  out  3  current state, debug
- halted  out  1  high in HALT
- instr_count  out  32  retired instruction count

Behaviour:
- Reset value:
  - state=INIT (000); instr_count=0.
  - ControlWord=0 (no RW, MW, IL; PS=00 hold).
  - constant=0; halted=0.
- ControlWord and constant are combinational from state, IR and the internal zero flag.
- NS field always equals the next-state encoding; CGS always 000.
- Field encodings:
  - PS: 00 hold, 01 PC+4, 10 PC+constant.
  - AS: 1 puts PC on the address bus.
  - DS: 00 ALU, 01 B, 11 memory.
- Default for every unlisted field is 0.
- States and transitions:
  - INIT (000) -> FETCH unconditionally; all controls zero.
  - FETCH (001): AS=1, DS=11, IL=1, PS=01, size=10 (32-bit). -> EXEC.
  - EXEC (010): decode IR, act per the instruction list below. Default next state FETCH; exceptions: CBZ -> EXEC2, unknown opcode -> HALT.
  - EXEC2 (011): CBZ only. If zf=1: PS=10, constant=SignExt(imm19)*4-4. Otherwise PS=00. -> FETCH.
  - HALT (111): all controls zero, halted=1; exits only by reset.
- EXEC actions by instruction (Rd=IR[4:0], Rn=IR[9:5], Rm=IR[20:16], Rt=IR[4:0]):
  - ADD/SUB/AND/ORR: IR[31:21] = 10001011000 / 11001011000 / 10001010000 / 10101010000. DA=Rd, SA=Rn, SB=Rm, Bsel=0, DS=00, RW=1. FS per op; C0=1 for SUB only.
  - ADDI/SUBI: IR[31:22] = 1001000100 / 1101000100. Bsel=1, constant=ZeroExt(IR[21:10]). Otherwise as ADD/SUB.
  - LDUR: IR[31:21]=11111000010. SA=Rn, Bsel=1, constant=SignExt(IR[20:12]), FS_ADD, AS=0, DS=11, size=MEM_SIZE, DA=Rt, RW=1.
  - STUR: IR[31:21]=11111000000. As LDUR, but SB=Rt, DS=01, MW=1, RW=0.
  - B: IR[31:26]=000101. PS=10, constant=SignExt(IR[25:0])*4-4, because PC was already advanced in FETCH.
  - CBZ: IR[31:24]=10110100. SA=Rt, FS_PASSA, no writes. At the clock edge, register zf<=cur_status[0].
- Decode priority: exact-match opcode compare; the 11-bit opcodes are checked before ADDI/SUBI, then CBZ, then B.
- instr_count increments by 1 (wrapping at 2^32) on the edge that leaves EXEC for FETCH, or that leaves EXEC2. No increment on entering HALT.
- DA=31 writes are issued unchanged; XZR handling belongs to the register file.
- An asynchronous reset in any state returns immediately to INIT with all outputs at reset values, including mid-CBZ (zf cleared).

Test Plan:
- Release reset -> state sequence INIT, FETCH, EXEC. FETCH word has IL=1, PS=01, AS=1, DS=11, NS=010.
- IR=0x8B020020 (ADD X0,X1,X2) in EXEC -> DA=0, SA=1, SB=2, RW=1, FS=FS_ADD, C0=0. instr_count 0->1 after the EXEC edge.
- IR=LDUR X3,[X4,#-8] -> constant=0xFFFFFFFFFFFFFFF8, Bsel=1, DS=11, RW=1, DA=3, MW=0. STUR same imm -> MW=1, DS=01, RW=0.
- CBZ X5,#+3 with cur_status Z=1 in EXEC -> EXEC2 has PS=10, constant=8. Repeat with Z=0 -> PS=00. Count increments once per CBZ.
- B #-1 -> PS=10, constant=0xFFFFFFFFFFFFFFF8. IR=0xFFFFFFFF in EXEC -> HALT, halted=1, count unchanged, stays halted 10 cycles.
- Assert reset while in EXEC2 -> state=INIT and ControlWord=0 immediately, instr_count=0.
